// File: rtl/key_expansion_pkg.sv
// Shared constants and helpers for the iterative AES key-schedule generator.
// The key-size select x is 0/1/2 for AES-128/192/256.
package key_expansion_pkg;

  typedef enum logic [1:0] {
    StIdle   = 2'd0,
    StExpand = 2'd1,
    StDone   = 2'd2
  } state_e;

  function automatic int unsigned calc_nk(input int unsigned sel);
    return 4 + 2 * sel;
  endfunction

  function automatic int unsigned calc_nr(input int unsigned sel);
    return 10 + 2 * sel;
  endfunction

  function automatic int unsigned calc_nw(input int unsigned sel);
    return 4 * (calc_nr(sel) + 1);
  endfunction

  // Multiply by {02} in GF(2^8), used to advance the round constant.
  function automatic logic [7:0] xtime(input logic [7:0] b);
    return {b[6:0], 1'b0} ^ (b[7] ? 8'h1b : 8'h00);
  endfunction

endpackage

// File: rtl/aes_sbox.sv
// Combinational AES forward S-box (the same table used by sub_bytes).
module aes_sbox (
  input  logic [7:0] i_byte,
  output logic [7:0] o_byte
);

  // Entry 0 sits in the top byte, so entry n is found at bit offset 8*(255-n).
  localparam logic [2047:0] SboxTable = {
    128'h637c777bf26b6fc53001672bfed7ab76,
    128'hca82c97dfa5947f0add4a2af9ca472c0,
    128'hb7fd9326363ff7cc34a5e5f171d83115,
    128'h04c723c31896059a071280e2eb27b275,
    128'h09832c1a1b6e5aa0523bd6b329e32f84,
    128'h53d100ed20fcb15b6acbbe394a4c58cf,
    128'hd0efaafb434d338545f9027f503c9fa8,
    128'h51a3408f929d38f5bcb6da2110fff3d2,
    128'hcd0c13ec5f974417c4a77e3d645d1973,
    128'h60814fdc222a908846eeb814de5e0bdb,
    128'he0323a0a4906245cc2d3ac629195e479,
    128'he7c8376d8dd54ea96c56f4ea657aae08,
    128'hba78252e1ca6b4c6e8dd741f4bbd8b8a,
    128'h703eb5664803f60e613557b986c11d9e,
    128'he1f8981169d98e949b1e87e9ce5528df,
    128'h8ca1890dbfe6426841992d0fb054bb16
  };

  assign o_byte = SboxTable[{~i_byte, 3'b000} +: 8];

endmodule

// File: rtl/key_expansion_sub_word.sv
// SubWord: the byte S-box applied independently to each byte of a 32-bit word.
module sub_word (
  input  logic [31:0] i_word,
  output logic [31:0] o_word
);

  for (genvar g = 0; g < 4; g++) begin : g_sbox
    aes_sbox u_sbox (
      .i_byte (i_word[8*g +: 8]),
      .o_byte (o_word[8*g +: 8])
    );
  end

endmodule

// File: rtl/key_expansion.sv
// Iterative AES key schedule: loads the cipher key on start, then derives one
// 32-bit schedule word per clock until the full expanded-key bus is valid.
import key_expansion_pkg::*;

module key_expansion #(
  parameter int unsigned x = 0
) (
  input  logic                          clk,
  input  logic                          rst,
  input  logic                          start,
  input  logic [32*calc_nk(x)-1:0]      key,
  output logic [32*calc_nw(x)-1:0]      words,
  output logic                          busy,
  output logic                          done
);

  localparam int unsigned Nk      = calc_nk(x);
  localparam int unsigned NW      = calc_nw(x);
  localparam logic [5:0]  NkIdx   = 6'(Nk);
  localparam logic [5:0]  LastIdx = 6'(NW - 1);
  localparam logic [2:0]  ModLast = 3'(Nk - 1);

  state_e      r_state;
  logic [31:0] r_w [NW];
  logic [5:0]  r_i;
  logic [2:0]  r_mod;
  logic [7:0]  r_rcon;
  logic        r_busy;
  logic        r_done;

  logic [31:0] w_prev;
  logic [31:0] w_old;
  logic [31:0] w_sub_in;
  logic [31:0] w_sub_out;
  logic [31:0] w_temp;
  logic [31:0] w_next;

  assign w_prev = r_w[r_i - 6'd1];
  assign w_old  = r_w[r_i - NkIdx];

  // One S-box datapath serves both the RotWord case and the AES-256 mid-block case.
  assign w_sub_in = (r_mod == 3'd0) ? {w_prev[23:0], w_prev[31:24]} : w_prev;

  sub_word u_sub_word (
    .i_word (w_sub_in),
    .o_word (w_sub_out)
  );

  always_comb begin
    w_temp = w_prev;
    if (r_mod == 3'd0) begin
      w_temp = w_sub_out ^ {r_rcon, 24'h000000};
    end else if (Nk == 8 && r_mod == 3'd4) begin
      w_temp = w_sub_out;
    end
    w_next = w_old ^ w_temp;
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state <= StIdle;
      for (int unsigned j = 0; j < NW; j++) begin
        r_w[j[5:0]] <= '0;
      end
      r_i    <= '0;
      r_mod  <= '0;
      r_rcon <= 8'h01;
      r_busy <= 1'b0;
      r_done <= 1'b0;
    end else begin
      unique case (r_state)
        StIdle, StDone: begin
          if (start) begin
            for (int unsigned j = 0; j < Nk; j++) begin
              r_w[j[5:0]] <= key[32*(Nk-1-j) +: 32];
            end
            r_i     <= NkIdx;
            r_mod   <= '0;
            r_rcon  <= 8'h01;
            r_busy  <= 1'b1;
            r_done  <= 1'b0;
            r_state <= StExpand;
          end
        end
        StExpand: begin
          r_w[r_i] <= w_next;
          r_i      <= r_i + 6'd1;
          r_mod    <= (r_mod == ModLast) ? 3'd0 : r_mod + 3'd1;
          if (r_mod == 3'd0) begin
            r_rcon <= xtime(r_rcon);
          end
          if (r_i == LastIdx) begin
            r_busy  <= 1'b0;
            r_done  <= 1'b1;
            r_state <= StDone;
          end
        end
        default: r_state <= StIdle;
      endcase
    end
  end

  for (genvar g = 0; g < NW; g++) begin : g_words
    assign words[32*g +: 32] = r_w[g];
  end

  assign busy = r_busy;
  assign done = r_done;

endmodule

// File: tb/tb_key_expansion.sv
// Directed checks of key_expansion for all three key sizes against FIPS-197 vectors.
module tb_key_expansion;

  localparam logic [127:0] KeyA1 = 128'h2b7e151628aed2a6abf7158809cf4f3c;
  localparam logic [127:0] KeyC1 = 128'h000102030405060708090a0b0c0d0e0f;
  localparam logic [191:0] Key192 = 192'h8e73b0f7da0e6452c810f32b809079e562f8ead2522c6b7b;
  localparam logic [255:0] Key256 =
    256'h603deb1015ca71be2b73aef0857d77811f352c073b6108d72d9810a30914dff4;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          start0 = 1'b0, start1 = 1'b0, start2 = 1'b0;
  logic [127:0]  key0 = '0;
  logic [191:0]  key1 = '0;
  logic [255:0]  key2 = '0;
  logic [1407:0] words0;
  logic [1663:0] words1;
  logic [1919:0] words2;
  logic          busy0, busy1, busy2;
  logic          done0, done1, done2;

  int n_tests = 0;
  int n_fail  = 0;

  always #5 clk = ~clk;

  key_expansion #(.x(0)) dut0 (
    .clk(clk), .rst(rst), .start(start0), .key(key0), .words(words0), .busy(busy0), .done(done0)
  );
  key_expansion #(.x(1)) dut1 (
    .clk(clk), .rst(rst), .start(start1), .key(key1), .words(words1), .busy(busy1), .done(done1)
  );
  key_expansion #(.x(2)) dut2 (
    .clk(clk), .rst(rst), .start(start2), .key(key2), .words(words2), .busy(busy2), .done(done2)
  );

  task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %08h expected %08h", tag, got, exp);
    end
  endtask

  function automatic logic [31:0] get_w(input int which, input int idx);
    case (which)
      0:       return words0[32*idx +: 32];
      1:       return words1[32*idx +: 32];
      default: return words2[32*idx +: 32];
    endcase
  endfunction

  function automatic logic sel_done(input int which);
    case (which)
      0:       return done0;
      1:       return done1;
      default: return done2;
    endcase
  endfunction

  function automatic logic sel_busy(input int which);
    case (which)
      0:       return busy0;
      1:       return busy1;
      default: return busy2;
    endcase
  endfunction

  // Drive a one-cycle start; returns 1 ns after the capturing edge E0.
  task automatic pulse(input int which);
    @(negedge clk);
    case (which)
      0:       start0 = 1'b1;
      1:       start1 = 1'b1;
      default: start2 = 1'b1;
    endcase
    @(posedge clk);
    #1;
    start0 = 1'b0;
    start1 = 1'b0;
    start2 = 1'b0;
  endtask

  // Counts edges until done rises and samples of busy=1 seen on the way (bounded).
  task automatic wait_done(input int which, output int edges, output int busy_cnt);
    edges    = 0;
    busy_cnt = 0;
    while (!sel_done(which) && edges < 100) begin
      if (sel_busy(which)) busy_cnt++;
      @(posedge clk);
      #1;
      edges++;
    end
  endtask

  int edges, bcnt;

  initial begin
    #12;
    check_eq("rst_busy0", {31'b0, busy0}, 32'd0);
    check_eq("rst_done0", {31'b0, done0}, 32'd0);
    check_eq("rst_words0_any", {31'b0, |words0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;

    // AES-128 FIPS-197 A.1
    key0 = KeyA1;
    pulse(0);
    check_eq("a1_busy_at_e0", {31'b0, busy0}, 32'd1);
    check_eq("a1_w0", get_w(0, 0), 32'h2b7e1516);
    check_eq("a1_w3", get_w(0, 3), 32'h09cf4f3c);
    wait_done(0, edges, bcnt);
    check_eq("a1_latency", edges, 32'd40);
    check_eq("a1_busy_cycles", bcnt, 32'd40);
    check_eq("a1_busy_low", {31'b0, busy0}, 32'd0);
    check_eq("a1_w4", get_w(0, 4), 32'ha0fafe17);
    check_eq("a1_w5", get_w(0, 5), 32'h88542cb1);
    check_eq("a1_w40", get_w(0, 40), 32'hd014f9a8);
    check_eq("a1_w43", get_w(0, 43), 32'hb6630ca6);
    repeat (5) @(posedge clk);
    #1;
    check_eq("a1_done_held", {31'b0, done0}, 32'd1);
    check_eq("a1_w43_held", get_w(0, 43), 32'hb6630ca6);

    // AES-192
    key1 = Key192;
    pulse(1);
    wait_done(1, edges, bcnt);
    check_eq("k192_latency", edges, 32'd46);
    check_eq("k192_w6", get_w(1, 6), 32'hfe0c91f7);
    check_eq("k192_w51", get_w(1, 51), 32'h01002202);

    // AES-256
    key2 = Key256;
    pulse(2);
    wait_done(2, edges, bcnt);
    check_eq("k256_latency", edges, 32'd52);
    check_eq("k256_w8", get_w(2, 8), 32'h9ba35411);
    check_eq("k256_w59", get_w(2, 59), 32'h706c631e);

    // Start while busy is ignored
    key0 = KeyA1;
    pulse(0);
    repeat (9) @(posedge clk);
    #1;
    key0 = KeyC1;
    pulse(0);
    check_eq("ign_busy", {31'b0, busy0}, 32'd1);
    wait_done(0, edges, bcnt);
    check_eq("ign_latency", edges + 10, 32'd40);
    check_eq("ign_w43", get_w(0, 43), 32'hb6630ca6);

    // Start after done restarts with the new key
    pulse(0);
    check_eq("rs_done_drop", {31'b0, done0}, 32'd0);
    check_eq("rs_busy", {31'b0, busy0}, 32'd1);
    wait_done(0, edges, bcnt);
    check_eq("rs_latency", edges, 32'd40);
    check_eq("rs_w0", get_w(0, 0), 32'h00010203);
    check_eq("rs_w4", get_w(0, 4), 32'hd6aa74fd);
    check_eq("rs_w43", get_w(0, 43), 32'h4d2b30c5);

    // Asynchronous reset mid-expansion
    key0 = KeyA1;
    pulse(0);
    repeat (19) @(posedge clk);
    #3;
    rst = 1'b1;
    #1;
    check_eq("mid_rst_busy", {31'b0, busy0}, 32'd0);
    check_eq("mid_rst_done", {31'b0, done0}, 32'd0);
    check_eq("mid_rst_words_any", {31'b0, |words0}, 32'd0);
    @(negedge clk);
    rst = 1'b0;
    pulse(0);
    wait_done(0, edges, bcnt);
    check_eq("post_rst_latency", edges, 32'd40);
    check_eq("post_rst_w4", get_w(0, 4), 32'ha0fafe17);
    check_eq("post_rst_w43", get_w(0, 43), 32'hb6630ca6);

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
